// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the I-memory read port and
// holds a redirect that lands during a stall. Optional fetch counter: IFU_FETCH_CNT_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        d_redirect,
  input  logic [31:0] d_redirect_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_new_instr
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  logic [31:0] pc_r;
  logic        pend_valid_r;
  logic [31:0] pend_pc_r;

  logic [31:0] pc_nxt_s;
  logic        pend_valid_nxt_s;
  logic [31:0] pend_pc_nxt_s;
  logic        legal_s;
  logic [32:0] pc_ext_s;
  logic [32:0] base_ext_s;
  logic [32:0] span_s;

  // Range check done in 33 bits so neither the subtraction nor the span can wrap.
  always_comb begin
    pc_ext_s   = {1'b0, pc_r};
    base_ext_s = {1'b0, IM_BASE};
    span_s     = 33'(IM_WORDS) * 33'd4;
    legal_s    = (pc_r[1:0] == 2'b00) &&
                 (pc_ext_s >= base_ext_s) &&
                 ((pc_ext_s - base_ext_s) < span_s);
  end

  // Fetch outputs; an illegal PC yields a nop bubble.
  always_comb begin
    i_inst_addr = pc_r;
    f_pc        = pc_r;
    f_new_instr = legal_s;
    if (legal_s) begin
      f_instr = i_inst_rdata;
    end else begin
      f_instr = 32'h0000_0000;
    end
  end

  // Next-PC selection and pending-redirect capture while stalled.
  always_comb begin
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    if (halt) begin
      if (d_redirect) begin
        pend_valid_nxt_s = 1'b1;
        pend_pc_nxt_s    = d_redirect_pc;
      end else begin
        pend_valid_nxt_s = pend_valid_r;
        pend_pc_nxt_s    = pend_pc_r;
      end
    end else begin
      // A live redirect supersedes any pending one; either way the pending slot empties.
      pend_valid_nxt_s = 1'b0;
      if (d_redirect) begin
        pc_nxt_s = d_redirect_pc;
      end else if (pend_valid_r) begin
        pc_nxt_s = pend_pc_r;
      end else begin
        pc_nxt_s = pc_r + 32'd4;
      end
    end
  end

  // PC and pending-redirect state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'h0000_0000;
    end else begin
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
    end
  end

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt_r;

  // Counts legally fetched words that advance out of F.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_r <= 32'h0000_0000;
    end else if (!halt && legal_s) begin
      fetch_cnt_r <= fetch_cnt_r + 32'd1;
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  assign fetch_cnt = fetch_cnt_r;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch; also checks fetch_cnt when
// IFU_FETCH_CNT_EN is defined.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        d_redirect = 1'b0;
  logic [31:0] d_redirect_pc = 32'h0000_0000;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_new_instr;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic        cur_legal = 1'b0;
  logic [31:0] cnt_exp = 32'h0000_0000;

  always #5 clk = ~clk;

  // Instruction memory model: every address holds a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  ifu_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .d_redirect   (d_redirect),
    .d_redirect_pc(d_redirect_pc),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .f_pc         (f_pc),
    .f_instr      (f_instr),
    .f_new_instr  (f_new_instr)
`ifdef IFU_FETCH_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt)
`endif
  );

  typedef struct {
    logic        halt;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        legal;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic h, input logic r, input logic [31:0] rpc,
                              input logic [31:0] pc, input logic legal);
    vec_t v;
    v.halt = h; v.redir = r; v.rpc = rpc; v.pc = pc; v.legal = legal;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and update the fetch counter model.
  task automatic step(input logic rst, input logic h, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; halt = h; d_redirect = r; d_redirect_pc = rpc;
    @(posedge clk);
    if (rst) cnt_exp = 32'h0000_0000;
    else if (!h && cur_legal) cnt_exp = cnt_exp + 32'd1;
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc, input logic legal);
    cmp({tag, ".f_pc"}, f_pc, pc);
    cmp({tag, ".i_inst_addr"}, i_inst_addr, pc);
    cmp({tag, ".f_new_instr"}, {31'd0, f_new_instr}, {31'd0, legal});
    cmp({tag, ".f_instr"}, f_instr, legal ? mem_word(pc) : 32'h0000_0000);
`ifdef IFU_FETCH_CNT_EN
    cmp({tag, ".fetch_cnt"}, fetch_cnt, cnt_exp);
`endif
    cur_legal = legal;
  endtask

  initial begin
    // Sequential fetch, then a 3-cycle stall at 3008.
    add(1'b0, 1'b0, 32'h0,         32'h0000_3004, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3008, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3008, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3008, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3008, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_300C, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3010, 1'b1);
    // Delay slot 3010 presented once, then redirect target.
    add(1'b0, 1'b1, 32'h0000_3100, 32'h0000_3100, 1'b1);
    add(1'b0, 1'b1, 32'h0000_3010, 32'h0000_3010, 1'b1);
    // Redirect held across a stall.
    add(1'b1, 1'b1, 32'h0000_3200, 32'h0000_3010, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3010, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3010, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3200, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3204, 1'b1);
    // Live redirect in the release cycle wins and drops the pending one.
    add(1'b0, 1'b1, 32'h0000_3010, 32'h0000_3010, 1'b1);
    add(1'b1, 1'b1, 32'h0000_3200, 32'h0000_3010, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3010, 1'b1);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3010, 1'b1);
    add(1'b0, 1'b1, 32'h0000_3300, 32'h0000_3300, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3304, 1'b1);
    // Latest stalled redirect overwrites the earlier one.
    add(1'b1, 1'b1, 32'h0000_3400, 32'h0000_3304, 1'b1);
    add(1'b1, 1'b1, 32'h0000_3500, 32'h0000_3304, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3500, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3504, 1'b1);
    // Illegal fetches: misaligned, below base, at/after top, PC wrap.
    add(1'b0, 1'b1, 32'h0000_3002, 32'h0000_3002, 1'b0);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3006, 1'b0);
    add(1'b1, 1'b0, 32'h0,         32'h0000_3006, 1'b0);
    add(1'b0, 1'b1, 32'h0000_2FFC, 32'h0000_2FFC, 1'b0);
    add(1'b0, 1'b0, 32'h0,         32'h0000_3000, 1'b1);
    add(1'b0, 1'b1, 32'h0000_6FFC, 32'h0000_6FFC, 1'b1);
    add(1'b0, 1'b0, 32'h0,         32'h0000_7000, 1'b0);
    add(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    add(1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b0);
    add(1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, 1'b1);

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_state("reset", 32'h0000_3000, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].halt, vecs[i].redir, vecs[i].rpc);
      expect_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].legal);
    end

    // Reset overrides halt and redirect and clears a pending redirect.
    step(1'b0, 1'b1, 1'b1, 32'h0000_3800);
    expect_state("rst_seq.pend", 32'h0000_3000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3900);
    expect_state("rst_seq.reset", 32'h0000_3000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_state("rst_seq.after", 32'h0000_3004, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_state("rst_seq.after2", 32'h0000_3008, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Directly upstream of the F/D pipeline register; feeds it f_pc, f_instr and f_new_instr.
- Owns the architectural fetch PC and drives the external instruction-memory read port.
- Applies stalls from the hazard unit and control-flow redirects from the decode stage (delay-slot semantics); holds a redirect that arrives during a stall until it is consumed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_WORDS, 4096, number of 32-bit words in instruction memory; legal range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- halt  input  1  stall from hazard unit; fetch PC holds
- d_redirect  input  1  decode stage requests control transfer (branch taken / j / jal / jr / jalr)
- d_redirect_pc  input  32  target address for d_redirect
- i_inst_addr  output  32  instruction-memory read address, equals current PC (combinational)
- i_inst_rdata  input  32  instruction-memory read data, combinational w.r.t. i_inst_addr
- f_pc  output  32  PC of the instruction presented this cycle
- f_instr  output  32  fetched instruction, or 32'h0 (nop) when the fetch is illegal
- f_new_instr  output  1  1 = f_instr is a legally fetched word; 0 = nop bubble

Behaviour:
- State: pc[31:0], pend_valid, pend_pc[31:0].
- Reset (synchronous, on edge with reset=1): pc=RESET_PC, pend_valid=0, pend_pc=0. Reset overrides halt and d_redirect.
- Outputs (combinational from pc):
  - i_inst_addr = f_pc = pc.
  - legal = (pc[1:0]==2'b00) && (pc >= IM_BASE) && (pc - IM_BASE < 4*IM_WORDS), compared in 33-bit unsigned arithmetic so no wrap-around.
  - f_instr = legal ? i_inst_rdata : 32'h0.
  - f_new_instr = legal.
  - First cycle after reset: f_pc=RESET_PC, f_new_instr=1 with default parameters.
- Next-PC when halt=0, priority high to low:
  - d_redirect=1: pc <= d_redirect_pc.
  - pend_valid=1: pc <= pend_pc.
  - otherwise pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0, and the result is illegal).
  - pend_valid is cleared on every non-halted edge, whether or not pend_pc was used.
- Delay slot: the redirect arrives while the delay-slot instruction is in F, so the delay slot is always fetched. The block never squashes it.
- When halt=1:
  - pc holds.
  - If d_redirect=1: pend_valid <= 1 and pend_pc <= d_redirect_pc. The latest redirect overwrites any earlier pending one.
  - If d_redirect=0: pend_valid and pend_pc hold.
- An illegal PC is not trapped here. Fetch continues sequentially from it (pc+4) until redirected; bubbles are emitted meanwhile.
- Latency: a redirect sampled at edge N is visible on f_pc from edge N onward (one cycle after the d_redirect assertion cycle).

Optional Feature:
- Macro: IFU_FETCH_CNT_EN.
- Defined: adds output port fetch_cnt [31:0].
  - Reset value 0.
  - Increments by 1 on each edge where halt=0, reset=0 and f_new_instr=1.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Holds during halt.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 4 free cycles, im[0..3]=A,B,C,D -> f_pc 3000,3004,3008,300C; f_instr A,B,C,D; f_new_instr=1.
- pc=3008, halt=1 for 3 cycles -> f_pc stays 3008 and f_instr stays im[2]. Release -> f_pc 300C.
- At pc=3010 (delay slot), d_redirect=1, target 3100 -> next f_pc=3100. The 3010 word is presented exactly once, with no bubble.
- At pc=3010, halt=1 with d_redirect=1, target 3200 for one cycle, then d_redirect=0 with halt held 2 more cycles, then halt=0 -> f_pc goes 3010,3010,3010,3200.
- Same as the previous scenario, but d_redirect=1 (target 3300) in the release cycle -> f_pc=3300; pend_valid cleared.
- Redirect to 3002 -> f_new_instr=0, f_instr=0, next f_pc=3006. Redirect to 2FFC -> bubble. Redirect to 3000+4*IM_WORDS -> bubble. With IFU_FETCH_CNT_EN, fetch_cnt does not increment in bubble cycles.
